// File: rtl/ysyx_23060184_pipe_stage_pkg.sv
//------------------------------------------------------------------------------
// Module   : ysyx_23060184_pipe_stage_pkg
// Brief    : Shared defines for the inter-stage pipeline registers: per-stage
//            payload widths and bit positions inside the control vector.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ysyx_23060184_pipe_stage_pkg;

    // Default widths used by every stage register instance
    localparam int PIPE_CTRL_W = 16;
    localparam int PIPE_DATA_W = 128;

    // Bit positions of the side-effect control vector
    typedef enum logic [3:0] {
        CTRL_REGWRITE = 4'd0,
        CTRL_MEMWRITE = 4'd1,
        CTRL_MEMREAD  = 4'd2,
        CTRL_JAL      = 4'd3,
        CTRL_JALR     = 4'd4,
        CTRL_BRANCH   = 4'd5,
        CTRL_ECALL    = 4'd6,
        CTRL_MRET     = 4'd7,
        CTRL_CSRWRITE = 4'd8
    } ctrl_bit_e;

    // Masks a control vector so it can only carry side effects for a valid beat
    function automatic logic [PIPE_CTRL_W-1:0] gate_ctrl(
        input logic [PIPE_CTRL_W-1:0] ctrl,
        input logic                   valid
    );
        return ctrl & {PIPE_CTRL_W{valid}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060184_pipe_entry.sv
//------------------------------------------------------------------------------
// Module   : ysyx_23060184_pipe_entry
// Brief    : One storage slot of a pipeline register: valid bit, control
//            vector and payload. Flush and clear empty the slot and zero the
//            control bits; the payload only returns to zero on reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060184_pipe_entry #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Slot update: flush beats load, load beats clear; data survives emptying
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

`default_nettype wire

// File: rtl/ysyx_23060184_pipe_stage.sv
//------------------------------------------------------------------------------
// Module   : ysyx_23060184_pipe_stage
// Brief    : Valid/ready inter-stage pipeline register with synchronous flush.
//            Control bits are forced to zero whenever no beat is held.
//            Build option YSYX_23060184_PIPE_SKID_EN adds a second (skid)
//            entry so in_ready comes straight from a flop.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ysyx_23060184_pipe_stage
    import ysyx_23060184_pipe_stage_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              w_accept;
    logic              w_deliver;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_main_load;
    logic              w_main_clear;
    logic [CTRL_W-1:0] w_main_ld_ctrl;
    logic [DATA_W-1:0] w_main_ld_data;

    assign w_accept  = in_valid & in_ready;
    assign w_deliver = w_main_valid & out_ready;

    // Head of the stage: this entry always drives the downstream side
    ysyx_23060184_pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ld_ctrl),
        .i_data  (w_main_ld_data),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

`ifdef YSYX_23060184_PIPE_SKID_EN

    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_valid_nxt;
    logic              r_in_ready;

    // Main refills from skid first so beat order is preserved; it only takes
    // the input directly when skid is empty.
    assign w_main_load    = w_deliver ? (w_skid_valid | w_accept)
                                      : (~w_main_valid & w_accept);
    assign w_main_clear   = w_deliver & ~w_skid_valid & ~w_accept;
    assign w_main_ld_ctrl = w_skid_valid ? w_skid_ctrl : in_ctrl;
    assign w_main_ld_data = w_skid_valid ? w_skid_data : in_data;

    // Skid catches a beat that arrives while main is stalled, and drains
    // into main on the next delivery.
    assign w_skid_load  = w_accept & w_main_valid & ~w_deliver;
    assign w_skid_clear = w_deliver & w_skid_valid;

    assign w_skid_valid_nxt = flush       ? 1'b0 :
                              w_skid_load ? 1'b1 :
                              w_skid_clear ? 1'b0 : w_skid_valid;

    ysyx_23060184_pipe_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    // Registered ready: low during reset, then mirrors "skid will be empty"
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= ~w_skid_valid_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

`else

    // Single entry: accept whenever the slot is empty or is being drained now
    assign in_ready       = ~w_main_valid | out_ready;
    assign w_main_load    = w_accept;
    assign w_main_clear   = w_deliver & ~w_accept;
    assign w_main_ld_ctrl = in_ctrl;
    assign w_main_ld_data = in_data;
    assign occupancy      = {1'b0, w_main_valid};

`endif

    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_valid}};
    assign out_data  = w_main_data;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060184_pipe_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_ysyx_23060184_pipe_stage
// Brief    : Self-checking bench for ysyx_23060184_pipe_stage against a
//            queue-based reference model; follows YSYX_23060184_PIPE_SKID_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ysyx_23060184_pipe_stage;

`ifdef YSYX_23060184_PIPE_SKID_EN
    localparam bit c_SKID = 1'b1;
`else
    localparam bit c_SKID = 1'b0;
`endif
    localparam int c_CAP = c_SKID ? 2 : 1;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_ctrl;
    logic [127:0] out_data;
    logic [1:0]   occupancy;

    ysyx_23060184_pipe_stage #(
        .DATA_W (128),
        .CTRL_W (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO of held beats plus the last beat seen at the head
    typedef struct {
        logic [15:0]  c;
        logic [127:0] d;
    } beat_t;

    beat_t        q[$];
    logic [127:0] last_front;
    bit           armed;
    bit           m_acc;
    int           n_checks;
    int           n_pass;
    int           n_deliv;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock of stimulus: drive, compare against model, advance model
    task automatic cycle(input logic iv, input logic [15:0] ic, input logic [127:0] id,
                         input logic ordy, input logic fl);
        bit    exp_ready;
        bit    deliver;
        beat_t b;
        @(negedge clk);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (q.size() > 0) last_front = q[0].d;
        exp_ready = c_SKID ? (armed && q.size() < 2) : (q.size() == 0 || ordy);
        check("out_valid", out_valid, q.size() > 0);
        check("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : 16'h0);
        check("out_data", out_data, last_front);
        check("occupancy", occupancy, q.size());
        check("in_ready", in_ready, exp_ready);
        m_acc   = iv && exp_ready;
        deliver = (q.size() > 0) && ordy;
        @(posedge clk);
        if (deliver) n_deliv++;
        if (fl) begin
            q.delete();
        end else begin
            if (deliver) void'(q.pop_front());
            if (m_acc) begin
                b.c = ic;
                b.d = id;
                q.push_back(b);
            end
        end
        armed = 1'b1;
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 16'h0, 128'h0, ordy, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset      = 1'b0;
        armed      = 1'b0;
        q.delete();
        last_front = '0;
    endtask

    initial begin
        int           k;
        int           budget;
        logic [127:0] rd;

        n_checks = 0; n_pass = 0; n_deliv = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        armed = 1'b0; last_front = '0;

        // Reset values
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_ctrl", out_ctrl, 16'h0);
        check("rst_out_data", out_data, 128'h0);
        check("rst_occupancy", occupancy, 2'd0);
        check("rst_in_ready", in_ready, c_SKID ? 1'b0 : 1'b1);
        release_reset();

        // Single beat, then bubble with zero control
        cycle(1'b1, 16'h0005, 128'hA5, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Stream of 8 beats at full throughput
        n_deliv = 0;
        for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 128'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("stream_deliveries", n_deliv, 8);

        // Backpressure: upstream holds each beat until accepted
        k = 1;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 16'(k + 16'h10), 128'(k), 1'b0, 1'b0);
            if (m_acc) k++;
        end
        check("bp_occupancy", occupancy, 2'(c_CAP));
        check("bp_accepted", k - 1, c_CAP);
        budget = 20;
        while (k <= 3 && budget > 0) begin
            cycle(1'b1, 16'(k + 16'h10), 128'(k), 1'b1, 1'b0);
            if (m_acc) k++;
            budget--;
        end
        check("bp_all_fed", k, 4);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Flush while full and with an input beat offered
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hBEEF, 128'(100 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 128'h999, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("flush_empty", occupancy, 2'd0);

        // Flush coinciding with a delivery: logged once, stage empty afterwards
        cycle(1'b1, 16'h0042, 128'h4242, 1'b0, 1'b0);
        n_deliv = 0;
        cycle(1'b0, 16'h0, 128'h0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        check("flush_deliv_once", n_deliv, 1);

        // Asynchronous reset mid-stream
        cycle(1'b1, 16'h0077, 128'h7777, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        check("arst_pre_valid", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_ctrl", out_ctrl, 16'h0);
        check("arst_occupancy", occupancy, 2'd0);
        release_reset();
        idle(1'b1);

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            cycle(($urandom % 4) != 0, 16'($urandom), rd,
                  ($urandom % 3) != 0, ($urandom % 16) == 0);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_23060184_pipe_stage.md
# ysyx_23060184_pipe_stage

Parametrised inter-stage pipeline register for the ysyx_23060184 core, replacing the hand-written per-stage registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries one payload per beat over a valid/ready handshake. It has a synchronous flush for branch and trap squashing. Control bits read as zero whenever the stage holds no valid beat. An optional skid buffer registers the backward ready path.

## Interface
- DATA_W, 128: width of the non-side-effect payload (PC, operands, immediates, register indices).
- CTRL_W, 16: width of the side-effect control vector (RegWrite, MemWrite, Jal, branch, Ecall, Mret, ...).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all held beats.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_ctrl  input  CTRL_W  upstream control vector.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_ctrl  output  CTRL_W  control vector; all-zero whenever out_valid=0.
- out_data  output  DATA_W  payload; holds its last value when out_valid=0.
- occupancy  output  2  number of beats held (0..1, or 0..2 with skid).

## Operation
- A beat is accepted when in_valid and in_ready are both high at the edge. It is delivered when out_valid and out_ready are both high at the edge.
- Entries are stored as valid bit, control vector and data. Control storage is cleared whenever its entry is emptied (delivered without refill, or flushed). Data storage is never cleared except by reset.
- out_ctrl is the AND of the control storage with out_valid, so a bubble can never fire a side effect.
- Priority at the edge is reset, then flush, then handshake.
- Flush clears every entry's valid and control bits. An input beat accepted in a flush cycle is discarded. An output beat delivered in a flush cycle counts as consumed.
- out_valid is never dropped without a delivery or a flush. out_ctrl and out_data are stable while out_valid=1 and out_ready=0.
- Reset mid-operation discards all beats immediately, without waiting for an edge.
- Reset values: all valid bits 0, out_valid=0, out_ctrl=0, out_data=0, occupancy=0. In skid mode in_ready=0 during reset and 1 after reset deasserts. In no-skid mode in_ready=1, since the stage is empty.

## Timing
- Latency is 1 cycle from acceptance to out_valid for an empty stage. Throughput is 1 beat per cycle when out_ready=1.
- Without skid, in_ready = ~out_valid | out_ready, which is combinational from out_ready.
- With skid, in_ready = ~skid_valid is a register output with no combinational path from out_ready.
  - A beat accepted while the main entry is full and not delivered goes to the skid entry.
  - On delivery, skid moves into main and the incoming beat moves into skid if accepted. Order is always preserved.
- When occupancy=2, in_ready=0. It returns to 1 the cycle after the first delivery.
- Empty, with no input and no flush: occupancy holds 0.

## Configuration
- YSYX_23060184_PIPE_SKID_EN defined: 2-entry skid buffer, registered in_ready, occupancy ranges 0..2.
- Not defined: single entry, combinational in_ready, occupancy ranges 0..1 (bit 1 tied to 0).

## Structure
- The shared defines header holds the per-stage CTRL_W/DATA_W values and the control-vector bit positions as constants. Stage instances pack and unpack their control vectors through these constants.
- The module is flat except for one natural sub-module: ysyx_23060184_pipe_entry, which holds one valid/ctrl/data entry with load, clear and flush. It is instantiated once, or twice in skid mode.

## Test plan
- Reset, then a single beat with in_ctrl=16'h0005, in_data=128'hA5 and out_ready=1 → out_valid=1 with ctrl 16'h0005 one cycle later, then out_valid=0 and out_ctrl=0.
- Stream of 8 beats (data 1..8) with out_ready=1 → 8 consecutive deliveries in order, one per cycle.
- Hold out_ready=0 while feeding beats 1, 2, 3.
  - Skid mode: 1 and 2 are accepted, occupancy=2, in_ready=0, and 3 is held upstream.
  - No-skid mode: only 1 is accepted.
  - Releasing out_ready → deliveries 1, 2, 3 in order.
- Flush with occupancy=2 while in_valid=1 → next cycle occupancy=0, out_ctrl=0, and the input beat is lost.
- Assert reset asynchronously mid-stream with out_valid=1 → out_valid and out_ctrl drop to 0 before the next clk edge.
- Flush in the same cycle as a delivery (out_ready=1) → downstream logs the beat exactly once, and the stage is empty afterwards.
